// File: rtl/dcm_lock_supervisor.sv
// DCM start-up / lock-loss supervisor: pulses the DCM reset, waits for all locks,
// qualifies them as stable, then releases system reset. Optional DCM_LOSS_CNT_EN adds a loss counter.
module dcm_lock_supervisor #(
    parameter int NUM_LOCK     = 4,
    parameter int RST_PULSE    = 8,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int STABLE_CNT   = 1024,
    parameter int MAX_RETRY    = 7
) (
    input  logic                I_CLK50M,
    input  logic                I_RESET,
    input  logic [NUM_LOCK-1:0] I_LOCK,
    output logic                O_DCM_RST,
    output logic                O_SYS_RESET,
    output logic                O_ALL_LOCKED,
    output logic                O_FAIL,
    output logic [2:0]          O_RETRY_CNT,
    output logic [7:0]          O_LOSS_CNT
);

    // state  | meaning
    // RST    | DCM reset held for RST_PULSE cycles
    // WAIT   | DCM released, waiting for all locks within LOCK_TIMEOUT
    // STABLE | all locked, qualifying for STABLE_CNT cycles
    // RUN    | system out of reset
    // FAIL   | retries exhausted, held until I_RESET
    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_STABLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    localparam int CNT_MAX = (LOCK_TIMEOUT > STABLE_CNT) ? LOCK_TIMEOUT : STABLE_CNT;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CNT - 1);
    localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

    logic [NUM_LOCK-1:0] sync1_q, sync2_q;
    logic                all_locked_q;
    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          retry_q, retry_d;
    logic                dcm_rst_q, sys_reset_q, fail_q;

    always_ff @(posedge I_CLK50M or posedge I_RESET) begin
        if (I_RESET) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            all_locked_q <= 1'b0;
        end else begin
            sync1_q      <= I_LOCK;
            sync2_q      <= sync1_q;
            all_locked_q <= &sync2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            ST_RST: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (all_locked_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_RST;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_STABLE: begin
                cnt_d = cnt_q + 1'b1;
                if (!all_locked_q)            state_d = ST_WAIT;
                else if (cnt_q == STB_LAST)   state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!all_locked_q) state_d = ST_RST;
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
        // the shared counter restarts on every state entry
        if (state_d != state_q) cnt_d = '0;
        if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;
    end

    always_ff @(posedge I_CLK50M or posedge I_RESET) begin
        if (I_RESET) begin
            state_q     <= ST_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            dcm_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            dcm_rst_q   <= (state_d == ST_RST) || (state_d == ST_FAIL);
            sys_reset_q <= (state_d != ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

`ifdef DCM_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge I_CLK50M or posedge I_RESET) begin
        if (I_RESET) begin
            loss_q <= '0;
        end else if (state_q == ST_RUN && state_d == ST_RST && loss_q != 8'hFF) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign O_LOSS_CNT = loss_q;
`else
    assign O_LOSS_CNT = '0;
`endif

    assign O_DCM_RST    = dcm_rst_q;
    assign O_SYS_RESET  = sys_reset_q;
    assign O_ALL_LOCKED = all_locked_q;
    assign O_FAIL       = fail_q;
    assign O_RETRY_CNT  = retry_q;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Directed bench for dcm_lock_supervisor with short test parameters
// (RST_PULSE=4, LOCK_TIMEOUT=64, STABLE_CNT=16, MAX_RETRY=2).
module tb_dcm_lock_supervisor;

`ifdef DCM_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] lock = 4'h0;
    logic       dcm_rst, sys_reset, all_locked, fail;
    logic [2:0] retry;
    logic [7:0] loss;

    int n_pass  = 0;
    int n_total = 0;

    dcm_lock_supervisor #(
        .NUM_LOCK    (4),
        .RST_PULSE   (4),
        .LOCK_TIMEOUT(64),
        .STABLE_CNT  (16),
        .MAX_RETRY   (2)
    ) dut (
        .I_CLK50M    (clk),
        .I_RESET     (rst),
        .I_LOCK      (lock),
        .O_DCM_RST   (dcm_rst),
        .O_SYS_RESET (sys_reset),
        .O_ALL_LOCKED(all_locked),
        .O_FAIL      (fail),
        .O_RETRY_CNT (retry),
        .O_LOSS_CNT  (loss)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [3:0] lock;
        logic       dcm;
        logic       sr;
        logic       al;
        logic [7:0] loss;
    } vec_t;

    vec_t tbl [1:60];

    function automatic logic [31:0] outs();
        return {17'd0, dcm_rst, sys_reset, all_locked, fail, retry, loss};
    endfunction

    function automatic logic [31:0] pack(input logic d, input logic s, input logic a,
                                         input logic f, input logic [2:0] r, input logic [7:0] l);
        return {17'd0, d, s, a, f, r, l};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_values", outs(), pack(1, 1, 0, 0, 3'd0, 8'd0));
        rst = 1'b0;
    endtask

    initial begin
        int  max_loss;
        bool_t: begin end
        for (int i = 1; i <= 60; i++) begin
            tbl[i].lock = (i < 10) ? 4'h0 : ((i == 33) ? 4'hB : 4'hF);
            tbl[i].dcm  = (i <= 3) || (i >= 36 && i <= 39);
            tbl[i].al   = (i >= 12 && i <= 34) || (i >= 36);
            tbl[i].sr   = !((i >= 29 && i <= 35) || (i >= 57));
            tbl[i].loss = (LOSS_EN && i >= 36) ? 8'd1 : 8'd0;
        end

        // start-up, lock loss in RUN and restart
        #5;
        lock = 4'h0;
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            lock = tbl[i].lock;
            tick();
            check($sformatf("startup_row%0d", i), outs(),
                  pack(tbl[i].dcm, tbl[i].sr, tbl[i].al, 1'b0, 3'd0, tbl[i].loss));
        end

        // asynchronous reset while in RUN
        #3 rst = 1'b1;
        #1 check("async_reset_in_run", outs(), pack(1, 1, 0, 0, 3'd0, 8'd0));

        // no lock ever: two retries then FAIL
        lock = 4'h0;
        do_reset();
        begin
            bit hold_ok = 1'b1;
            for (int c = 1; c <= 260; c++) begin
                tick();
                if (c == 67)  check("retry_before_t1", {retry, dcm_rst}, {3'd0, 1'b0});
                if (c == 68)  check("retry_after_t1", {retry, dcm_rst}, {3'd1, 1'b1});
                if (c == 135) check("retry_before_t2", {29'd0, retry}, 32'd1);
                if (c == 136) check("retry_after_t2", {retry, dcm_rst}, {3'd2, 1'b1});
                if (c == 203) check("fail_before_t3", {31'd0, fail}, 32'd0);
                if (c == 204) check("fail_entry", outs(), pack(1, 1, 0, 1, 3'd2, 8'd0));
                if (c > 204 && !(fail && dcm_rst && sys_reset)) hold_ok = 1'b0;
            end
            check("fail_held", {31'd0, hold_ok}, 32'd1);
        end

        // one timeout, then a drop on the last STABLE cycle
        lock = 4'h0;
        do_reset();
        begin
            bit sr_ok = 1'b1;
            for (int c = 1; c <= 110; c++) begin
                lock = (c >= 72) ? ((c == 88) ? 4'h7 : 4'hF) : 4'h0;
                tick();
                if (c == 68)  check("stb_retry_taken", {29'd0, retry}, 32'd1);
                if (c == 89)  check("stb_locked_pre_drop", {31'd0, all_locked}, 32'd1);
                if (c == 90)  check("stb_drop_at_terminal", {31'd0, all_locked}, 32'd0);
                if (c == 91)  check("stb_drop_blocks_run", {31'd0, sys_reset}, 32'd1);
                if (c >= 72 && c <= 107 && !sys_reset) sr_ok = 1'b0;
                if (c == 107) check("stb_retry_kept", {retry, sys_reset}, {3'd1, 1'b1});
                if (c == 108) check("stb_run_after_relock", {retry, sys_reset}, {3'd0, 1'b0});
            end
            check("stb_no_early_run", {31'd0, sr_ok}, 32'd1);
        end

        // 300 lock losses from RUN
        lock = 4'hF;
        do_reset();
        max_loss = 0;
        for (int it = 0; it < 300; it++) begin
            int k;
            k = 0;
            while (sys_reset && k < 200) begin tick(); k++; end
            if (sys_reset) begin
                check("loss_wait_run_timeout", {31'd0, sys_reset}, 32'd0);
                break;
            end
            lock = 4'hE;
            tick();
            lock = 4'hF;
            k = 0;
            while (!sys_reset && k < 20) begin tick(); k++; end
            if (!sys_reset) begin
                check("loss_wait_reset_timeout", {31'd0, sys_reset}, 32'd1);
                break;
            end
            if (int'(loss) > max_loss) max_loss = int'(loss);
            if (it == 9) check("loss_after_10", {24'd0, loss}, LOSS_EN ? 32'd10 : 32'd0);
        end
        check("loss_saturated", {24'd0, loss}, LOSS_EN ? 32'd255 : 32'd0);
        check("loss_max_seen", max_loss, LOSS_EN ? 32'd255 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
